// File: rtl/display_pkg.sv
// Shared constants, FSM state type and the BCD-to-segment table for the
// 7-segment display driver. Segment bits are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  function automatic logic [6:0] seg7_of(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// One digit of segment encoding: BCD digit to active-low pattern, or dark
// when the digit is a blanked leading zero.
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] segs
);

  assign segs = blank ? SEG_BLANK : seg7_of(digit);

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter driving DIGITS active-low
// 7-segment groups, with leading-zero blanking, overflow dashes and a pending slot.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  load,
  input  logic [DATA_W-1:0]     value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int ID    = (DATA_W + 2) / 3;
  localparam int CNT_W = $clog2(DATA_W + 1);

  // Handshake: load is a single-cycle strobe that is always accepted; while
  // busy it lands in a 1-deep pending slot (newest wins). done pulses for one
  // cycle right after seg/ovf change; busy covers every cycle a conversion runs.

  state_t               state;
  logic [DATA_W-1:0]    shiftReg;
  logic [4*ID-1:0]      bcdAcc;
  logic [4*ID-1:0]      bcdAdj;
  logic [CNT_W-1:0]     cnt;
  logic                 pendValid;
  logic [DATA_W-1:0]    pendValue;
  logic [4*DIGITS-1:0]  digits;
  logic [DIGITS-1:0]    blank;
  logic [7*DIGITS-1:0]  encSeg;
  logic                 ovfNext;
  logic                 lzRun;
  logic                 restart;
  logic [DATA_W-1:0]    restartValue;

  always_comb begin
    bcdAdj = bcdAcc;
    for (int i = 0; i < ID; i++) begin
      if (bcdAcc[4*i +: 4] >= 4'd5) bcdAdj[4*i +: 4] = bcdAcc[4*i +: 4] + 4'd3;
    end
  end

  // Internal digits above the displayed range only matter for overflow.
  always_comb begin
    ovfNext = 1'b0;
    for (int i = DIGITS; i < ID; i++) begin
      if (bcdAcc[4*i +: 4] != 4'd0) ovfNext = 1'b1;
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : gDigit
    if (k < ID) begin : gReal
      assign digits[4*k +: 4] = bcdAcc[4*k +: 4];
    end else begin : gZero
      assign digits[4*k +: 4] = 4'd0;
    end
    seg7_encode uEnc (
      .digit (digits[4*k +: 4]),
      .blank (blank[k]),
      .segs  (encSeg[7*k +: 7])
    );
  end

  // A digit is blanked when it and every digit above it are zero.
  always_comb begin
    blank = '0;
    lzRun = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lzRun    = lzRun && (digits[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LZ != 0) && lzRun;
    end
  end

  assign restart      = pendValid || load;
  assign restartValue = load ? value : pendValue;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      seg       <= '1;
      pendValid <= 1'b0;
      pendValue <= '0;
      shiftReg  <= '0;
      bcdAcc    <= '0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shiftReg <= value;
            bcdAcc   <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcdAcc, shiftReg} <= {bcdAdj, shiftReg} << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) state <= FINISH;
          if (load) begin
            pendValid <= 1'b1;
            pendValue <= value;
          end
        end
        FINISH: begin
          ovf  <= ovfNext;
          seg  <= ovfNext ? {DIGITS{SEG_DASH}} : encSeg;
          done <= 1'b1;
          if (restart) begin
            shiftReg  <= restartValue;
            bcdAcc    <= '0;
            cnt       <= '0;
            pendValid <= 1'b0;
            state     <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: arithmetic reference model with per-cycle
// comparison, directed literal cases and randomized load traffic.
module tb_bcd_display_driver;

  localparam int W  = 16;
  localparam int ND = 4;

  logic        clk;
  logic        n_reset;
  logic        load;
  logic        loadC;
  logic [15:0] value;
  logic [7:0]  valueC;
  logic        busyA, doneA, ovfA;
  logic        busyB, doneB, ovfB;
  logic        busyC, doneC, ovfC;
  logic [27:0] segA, segB;
  logic [20:0] segC;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  bcd_display_driver #(.DATA_W(16), .DIGITS(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .n_reset(n_reset), .load(load), .value(value),
    .busy(busyA), .done(doneA), .ovf(ovfA), .seg(segA));

  bcd_display_driver #(.DATA_W(16), .DIGITS(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .n_reset(n_reset), .load(load), .value(value),
    .busy(busyB), .done(doneB), .ovf(ovfB), .seg(segB));

  bcd_display_driver #(.DATA_W(8), .DIGITS(3), .BLANK_LZ(1)) u_c (
    .clk(clk), .n_reset(n_reset), .load(loadC), .value(valueC),
    .busy(busyC), .done(doneC), .ovf(ovfC), .seg(segC));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  function automatic logic [27:0] exp_seg(input int v, input int nd, input bit blz);
    logic [27:0] r;
    int pw;
    r  = '1;
    pw = 1;
    if (v >= 10 ** nd) begin
      for (int k = 0; k < nd; k++) r[7*k +: 7] = 7'h3F;
    end else begin
      for (int k = 0; k < nd; k++) begin
        if (blz && k > 0 && v < pw) r[7*k +: 7] = 7'h7F;
        else r[7*k +: 7] = pat((v / pw) % 10);
        pw = pw * 10;
      end
    end
    return r;
  endfunction

  // reference model: countdown to the update edge plus a newest-wins pending slot
  int          m_rem;
  int          m_cur;
  int          m_pv;
  bit          m_pend, m_busy, m_done, m_ovf;
  logic [27:0] m_seg_a, m_seg_b;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_rem = 0; m_pend = 0; m_busy = 0; m_done = 0; m_ovf = 0;
      m_seg_a = '1; m_seg_b = '1;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        if (load) begin m_pend = 1; m_pv = int'(value); end
        m_rem--;
        if (m_rem == 0) begin
          m_ovf   = (m_cur >= 10 ** ND);
          m_seg_a = exp_seg(m_cur, ND, 1'b1);
          m_seg_b = exp_seg(m_cur, ND, 1'b0);
          m_done  = 1;
          if (m_pend) begin m_cur = m_pv; m_pend = 0; m_rem = W + 1; end
          else m_busy = 0;
        end
      end else if (load) begin
        m_cur = int'(value); m_rem = W + 1; m_busy = 1;
      end
    end
  end

  // scoreboard compare, every cycle on the inactive edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busyA", busyA, m_busy);
      check("doneA", doneA, m_done);
      check("ovfA",  ovfA,  m_ovf);
      check("segA",  segA,  m_seg_a);
      check("busyB", busyB, m_busy);
      check("doneB", doneB, m_done);
      check("ovfB",  ovfB,  m_ovf);
      check("segB",  segB,  m_seg_b);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] v, output int e);
    value = v;
    load  = 1'b1;
    tick();
    e     = cyc;
    load  = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int e);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (doneA) begin
        check(name, cyc - e, W + 1);
        return;
      end
    end
    check(name, 64'hDEAD, W + 1);
  endtask

  initial begin
    int e;
    int dones;
    bit gap;
    logic [27:0] s1, s2;

    n_reset = 1'b1; load = 1'b0; loadC = 1'b0; value = '0; valueC = '0;
    #2 n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset segA", segA, 28'hFFFFFFF);
    check("reset busyA", busyA, 1'b0);
    check("reset doneA", doneA, 1'b0);
    check("reset ovfA", ovfA, 1'b0);
    n_reset = 1'b1;
    cmp_en  = 1;
    tick();

    // value 0 and latency
    pulse_load(16'd0, e);
    wait_done_a("lat0", e);
    check("seg0", segA, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    check("ovf0", ovfA, 1'b0);

    // 123 with and without blanking
    pulse_load(16'd123, e);
    wait_done_a("lat123", e);
    check("seg123 blz", segA, {7'h7F, 7'h79, 7'h24, 7'h30});
    check("seg123 noblz", segB, {7'h40, 7'h79, 7'h24, 7'h30});

    // range boundary
    pulse_load(16'd9999, e);
    wait_done_a("lat9999", e);
    check("seg9999", segA, {4{7'h10}});
    check("ovf9999", ovfA, 1'b0);
    pulse_load(16'd10000, e);
    wait_done_a("lat10000", e);
    check("seg10000", segA, {4{7'h3F}});
    check("ovf10000", ovfA, 1'b1);
    pulse_load(16'd65535, e);
    wait_done_a("lat65535", e);
    check("ovf65535", ovfA, 1'b1);

    // loads while busy: newest pending value wins, busy never drops
    pulse_load(16'd5, e);
    repeat (3) tick();
    pulse_load(16'd7, e);
    repeat (3) tick();
    pulse_load(16'd8, e);
    dones = 0; gap = 0; s1 = '0; s2 = '0;
    for (int i = 0; i < 80; i++) begin
      if (dones < 2 && !doneA && !busyA) gap = 1;
      if (doneA) begin
        dones++;
        if (dones == 1) s1 = segA;
        else if (dones == 2) s2 = segA;
      end
      tick();
    end
    check("pend dones", dones, 2);
    check("pend first", s1, {7'h7F, 7'h7F, 7'h7F, 7'h12});
    check("pend second", s2, {7'h7F, 7'h7F, 7'h7F, 7'h00});
    check("pend busy gap", gap, 1'b0);

    // reset mid-conversion
    pulse_load(16'd4321, e);
    repeat (4) tick();
    n_reset = 1'b0;
    #1;
    check("abort seg", segA, 28'hFFFFFFF);
    check("abort busy", busyA, 1'b0);
    check("abort done", doneA, 1'b0);
    repeat (2) tick();
    n_reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (doneA) dones++;
    end
    check("abort no done", dones, 0);

    // narrow instance: DATA_W=8, DIGITS=3
    valueC = 8'd255;
    loadC  = 1'b1;
    tick();
    e      = cyc;
    loadC  = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        tick();
        if (doneC) begin
          seen = 1;
          check("latC", cyc - e, 9);
          check("segC 255", segC, {7'h24, 7'h12, 7'h12});
          check("ovfC 255", ovfC, 1'b0);
        end
      end
      if (!seen) check("latC timeout", 64'hDEAD, 9);
    end

    // randomized traffic, including loads during every phase
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 5))
        0:       value = 16'd9999;
        1:       value = 16'd10000;
        2:       value = 16'($urandom_range(0, 9));
        3:       value = 16'($urandom_range(0, 65535));
        4:       value = 16'd65535;
        default: value = 16'($urandom_range(0, 999));
      endcase
      tick();
    end
    load = 1'b0;
    repeat (45) tick();

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
